opl3_host_if: RTL and testbench
===============================

# opl3_host_if

Host-side register write bridge for the OPL3 core; it produces the `opl3_reg_wr` bus that the operator and channel control logic consume. It accepts OPL3-style port writes from the host bus: address-port writes, then data-port writes, with `host_addr[1]` selecting the bank. Data writes are queued in a FIFO and drained onto `opl3_reg_wr` as single-cycle write pulses, with optional minimum spacing. It also owns the global `is_new` (OPL3 mode) bit decoded from bank 1 register 0x05.

## Interface
- `FIFO_DEPTH`, 16: queue entries; power of 2, ≥2.
- `WR_GAP`, 4: idle cycles forced between consecutive write pulses when spacing is compiled in; ≥1.

- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous and active-high.
- `host_wr_en`  in  1  host write strobe, one write per asserted cycle.
- `host_addr`  in  2  bit0: 0 = address port, 1 = data port. bit1: bank select.
- `host_din`  in  8  host write data.
- `opl3_reg_wr`  out  18  register write bus:
  - [17] valid
  - [16] bank
  - [15:8] register address
  - [7:0] data
- `is_new`  out  1  OPL3 NEW mode bit.
- `fifo_full`  out  1  queue holds FIFO_DEPTH entries.
- `overflow`  out  1  sticky; a data write was dropped.
- `busy`  out  1  queue non-empty or drain FSM not IDLE.

## Operation
- **Address-port write** (`host_wr_en` and `host_addr[0]`=0):
  - `addr_latch` ← `host_din`; `bank_latch` ← `host_addr[1]`.
  - Nothing is queued.
- **Data-port write** (`host_wr_en` and `host_addr[0]`=1):
  - Pushes {`bank_latch`, `addr_latch`, `host_din`}.
  - The latches are unchanged, so repeated data writes reuse the same address.
- **Push acceptance:**
  - A push is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the push is dropped and `overflow` ← 1. `overflow` clears only on reset.
- **Drain FSM**, states IDLE, EMIT, GAP:
  - IDLE: if the queue is non-empty, pop the head into the output register and go to EMIT.
  - EMIT: `opl3_reg_wr[17]`=1 for exactly this cycle, with fields from the popped entry.
    - With spacing: next state GAP, counter ← WR_GAP−1.
    - Without spacing: if the queue is non-empty, pop again and stay in EMIT; else go to IDLE.
  - GAP: `opl3_reg_wr[17]`=0. Decrement the counter; at 0, go to IDLE.
- Outside EMIT, `opl3_reg_wr` is all zeros.
- **NEW mode bit:**
  - Updated when an EMIT carries bank=1, address=0x05: `is_new` ← data[0].
  - It changes in the cycle after that pulse, so it stays in order with the write stream.
- Queue order is strict FIFO; no entry is reordered or duplicated.
- **Outputs:** `fifo_full` = (count == FIFO_DEPTH); `busy` = (count≠0) | (state≠IDLE). Both are registered-state derived.

## Timing
- **Reset values:**
  - `opl3_reg_wr`=0, `is_new`=0, `overflow`=0, `fifo_full`=0, `busy`=0.
  - Queue empty, latches 0, state IDLE.
- **Reset mid-operation:**
  - The queue is flushed; the pulse in flight drops to 0 in the cycle after `reset` is sampled.
  - No queued write is emitted after reset.
- **Latency:** a data write sampled at edge E0 into an idle, empty block gives `opl3_reg_wr[17]`=1 during the cycle after edge E2 (2 cycles).
- **Pulse spacing:**
  - With spacing: consecutive pulses are exactly WR_GAP+2 cycles apart while the queue stays non-empty (EMIT, WR_GAP×GAP, IDLE).
  - Without spacing: one pulse per cycle.
- **Simultaneous address-port and data-port writes:** impossible, since there is one strobe per cycle.
- **Address write in the same cycle as a pop:** independent; the queued entry keeps its original address.

## Configuration
- Macro `OPL3_HOST_IF_WR_SPACING_EN`.
- **Defined:** the GAP state and `WR_GAP` counter are present, enforcing register write recovery time.
- **Undefined:**
  - The GAP state and counter are removed and `WR_GAP` is ignored.
  - Back-to-back pulses drain one entry per cycle.
  - Sustained 1-write/cycle input never overflows.

## Test plan
- **Basic write:** address write 0xBD (`host_addr`=00), then data write 0xC0 (`host_addr`=01) → `opl3_reg_wr`=0x2BDC0 for one cycle, 2 cycles after the data write; `busy` low afterwards.
- **NEW bit:** address write 0x05 with `host_addr`=10, then data 0x01 with `host_addr`=11 → `opl3_reg_wr`=0x30501 and `is_new`=1 from the next cycle. Repeating with data 0x00 → `is_new`=0.
- **Spacing on, WR_GAP=4:**
  - Stimulus: three data writes at cycles 0, 1, 2 to address 0x20, data 0x11, 0x22, 0x33.
  - Response: pulses at cycles 2, 8, 14, with data in order.
- **Spacing off, same stimulus:** pulses at cycles 2, 3, 4.
- **Overflow (spacing on, FIFO_DEPTH=16):** 32 consecutive data writes with data 0..31 →
  - `fifo_full` and `overflow` assert.
  - Emitted data is a strictly increasing subsequence with no duplicates.
  - Emitted count + dropped count = 32.
- **Reset mid-burst:** 5 entries queued, reset for 1 cycle →
  - no further pulses;
  - `busy`=0, `is_new`=0, `overflow`=0;
  - the next write behaves as in the basic write case.

Source files
------------

// File: rtl/opl3_host_if_if.sv
// opl3_host_if_if: host port-write bus (strobe, port/bank select, data) into the OPL3 register bridge
interface opl3_host_if_if;
  logic       host_wr_en;
  logic [1:0] host_addr;
  logic [7:0] host_din;
  modport master (output host_wr_en, host_addr, host_din);
  modport slave  (input  host_wr_en, host_addr, host_din);
endinterface

// File: rtl/opl3_host_if.sv
// opl3_host_if: host port writes -> FIFO -> single-cycle opl3_reg_wr pulses; OPL3_HOST_IF_WR_SPACING_EN adds WR_GAP recovery cycles
module opl3_host_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int WR_GAP     = 4
) (
  input  logic              clk,
  input  logic              reset,
  opl3_host_if_if.slave     host,
  output logic [17:0]       opl3_reg_wr,
  output logic              is_new,
  output logic              fifo_full,
  output logic              overflow,
  output logic              busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || WR_GAP < 1) begin : g_bad_cfg
    $error("opl3_host_if: FIFO_DEPTH must be a power of 2 >= 2 and WR_GAP >= 1");
  end
`ifdef OPL3_HOST_IF_WR_SPACING_EN
  localparam int GW = $clog2(WR_GAP + 1);
  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;
  logic [GW-1:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE, EMIT} state_t;
`endif
  state_t        state;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   count;
  logic [7:0]    addr_l;
  logic          bank_l;
  logic          st_v;
  logic [16:0]   st_d;
  logic          pop, accept;
`ifdef OPL3_HOST_IF_WR_SPACING_EN
  assign pop = state == IDLE && count != 0;
`else
  assign pop = count != 0;
`endif
  // a full queue still takes a push when the head leaves in the same cycle
  assign accept    = st_v && (count != (AW+1)'(FIFO_DEPTH) || pop);
  assign fifo_full = count == (AW+1)'(FIFO_DEPTH);
  assign busy      = count != 0 || state != IDLE;
  always_ff @(posedge clk)
    if (accept) mem[wp] <= st_d;
  always_ff @(posedge clk)
    if (reset) begin
      state       <= IDLE;
      wp          <= '0;
      rp          <= '0;
      count       <= '0;
      addr_l      <= '0;
      bank_l      <= 1'b0;
      st_v        <= 1'b0;
      st_d        <= '0;
      opl3_reg_wr <= '0;
      is_new      <= 1'b0;
      overflow    <= 1'b0;
`ifdef OPL3_HOST_IF_WR_SPACING_EN
      gap_cnt     <= '0;
`endif
    end else begin
      addr_l      <= host.host_wr_en && !host.host_addr[0] ? host.host_din : addr_l;
      bank_l      <= host.host_wr_en && !host.host_addr[0] ? host.host_addr[1] : bank_l;
      st_v        <= host.host_wr_en && host.host_addr[0];
      st_d        <= {bank_l, addr_l, host.host_din};
      wp          <= accept ? wp + 1'b1 : wp;
      rp          <= pop ? rp + 1'b1 : rp;
      count       <= count + (AW+1)'(accept) - (AW+1)'(pop);
      overflow    <= overflow | (st_v && !accept);
      opl3_reg_wr <= pop ? {1'b1, mem[rp]} : '0;
      // trails the pulse by one cycle so mode changes stay ordered with the write stream
      is_new      <= opl3_reg_wr[17] && opl3_reg_wr[16:8] == 9'h105 ? opl3_reg_wr[0] : is_new;
`ifdef OPL3_HOST_IF_WR_SPACING_EN
      case (state)
        IDLE:    state <= pop ? EMIT : IDLE;
        EMIT: begin
          state   <= GAP;
          gap_cnt <= GW'(WR_GAP - 1);
        end
        default: begin
          state   <= gap_cnt == 0 ? IDLE : GAP;
          gap_cnt <= gap_cnt == 0 ? gap_cnt : gap_cnt - 1'b1;
        end
      endcase
`else
      state       <= pop ? EMIT : IDLE;
`endif
    end
endmodule

// File: tb/tb_opl3_host_if.sv
// tb_opl3_host_if: directed stimulus against a queue/timestamp model of the host write bridge
module tb_opl3_host_if;
  localparam int DEPTH = 16;
  localparam int GAPN  = 4;
`ifdef OPL3_HOST_IF_WR_SPACING_EN
  localparam bit SP = 1'b1;
`else
  localparam bit SP = 1'b0;
`endif
  localparam int STEP = SP ? GAPN + 2 : 1;
  localparam int HOLD = SP ? GAPN : 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  opl3_host_if_if hb();
  logic [17:0] opl3_reg_wr;
  logic        is_new, fifo_full, overflow, busy;

  opl3_host_if #(.FIFO_DEPTH(DEPTH), .WR_GAP(GAPN)) dut (
    .clk(clk), .reset(reset), .host(hb),
    .opl3_reg_wr(opl3_reg_wr), .is_new(is_new), .fifo_full(fifo_full),
    .overflow(overflow), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  logic [16:0] mq[$];
  bit          m_st_v = 1'b0;
  logic [16:0] m_st_d = '0;
  logic [7:0]  m_addr = '0;
  bit          m_bank = 1'b0;
  int          last_pop = -1000;
  logic [17:0] e_wr = '0;
  bit          e_new = 1'b0;
  bit          e_ovf = 1'b0;
  int          drops = 0;
  bit          started = 1'b0;

  int          obs_cyc[$];
  logic [7:0]  obs_dat[$];
  bit          saw_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Model: a queue plus the edge of the last pop; a pop may happen STEP edges after the previous one
  always @(posedge clk) begin
    bit popped;
    cyc++;
    if (reset) begin
      mq.delete();
      m_st_v = 1'b0; m_st_d = '0; m_addr = '0; m_bank = 1'b0;
      last_pop = -1000; e_wr = '0; e_new = 1'b0; e_ovf = 1'b0;
      started = 1'b1;
    end else begin
      if (e_wr[17] && e_wr[16] && e_wr[15:8] == 8'h05) e_new = e_wr[0];
      popped = mq.size() > 0 && cyc >= last_pop + STEP;
      if (popped) begin
        e_wr = {1'b1, mq.pop_front()};
        last_pop = cyc;
      end else e_wr = '0;
      if (m_st_v) begin
        if (mq.size() < DEPTH || popped) mq.push_back(m_st_d);
        else begin
          e_ovf = 1'b1;
          drops++;
        end
      end
      m_st_v = hb.host_wr_en && hb.host_addr[0];
      m_st_d = {m_bank, m_addr, hb.host_din};
      if (hb.host_wr_en && !hb.host_addr[0]) begin
        m_addr = hb.host_din;
        m_bank = hb.host_addr[1];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("reg_wr", opl3_reg_wr, e_wr);
      chk("is_new", is_new, e_new);
      chk("fifo_full", fifo_full, mq.size() == DEPTH);
      chk("overflow", overflow, e_ovf);
      chk("busy", busy, mq.size() != 0 || cyc <= last_pop + HOLD);
      if (opl3_reg_wr[17] === 1'b1) begin
        obs_cyc.push_back(cyc);
        obs_dat.push_back(opl3_reg_wr[7:0]);
      end
      if (fifo_full === 1'b1) saw_full = 1'b1;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d, output int e);
    hb.host_wr_en = 1'b1;
    hb.host_addr  = a;
    hb.host_din   = d;
    @(posedge clk);
    #1;
    e = cyc;
    hb.host_wr_en = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e, e0;
    hb.host_wr_en = 1'b0;
    hb.host_addr  = 2'b00;
    hb.host_din   = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_reg_wr", opl3_reg_wr, 18'h0);
    chk("rst_is_new", is_new, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_fifo_full", fifo_full, 1'b0);
    chk("rst_busy", busy, 1'b0);

    wr(2'b00, 8'hBD, e);
    wr(2'b01, 8'hC0, e);
    step(2);
    chk("basic_pulse", opl3_reg_wr, 18'h2BDC0);
    step(1);
    chk("basic_after", opl3_reg_wr, 18'h0);
    step(HOLD + 1);
    chk("basic_busy", busy, 1'b0);

    wr(2'b10, 8'h05, e);
    wr(2'b11, 8'h01, e);
    step(2);
    chk("new_pulse", opl3_reg_wr, 18'h30501);
    chk("new_not_yet", is_new, 1'b0);
    step(1);
    chk("new_set", is_new, 1'b1);
    step(10);
    wr(2'b11, 8'h00, e);
    step(3);
    chk("new_clr", is_new, 1'b0);

    step(10);
    obs_cyc.delete(); obs_dat.delete();
    wr(2'b00, 8'h20, e);
    wr(2'b01, 8'h11, e0);
    wr(2'b01, 8'h22, e);
    wr(2'b01, 8'h33, e);
    step(30);
    chk("space_count", obs_cyc.size(), 3);
    for (int i = 0; i < 3 && i < obs_cyc.size(); i++) begin
      chk("space_cyc", obs_cyc[i] - e0, SP ? 2 + 6 * i : 2 + i);
      chk("space_dat", obs_dat[i], 8'h11 * (i + 1));
    end

    step(5);
    obs_cyc.delete(); obs_dat.delete();
    saw_full = 1'b0;
    drops = 0;
    wr(2'b00, 8'h20, e);
    for (int i = 0; i < 32; i++) wr(2'b01, 8'(i), e);
    step(200);
    chk("ovf_flag", overflow, SP);
    chk("ovf_saw_full", saw_full, SP);
    chk("ovf_emitted", obs_dat.size(), SP ? 22 : 32);
    chk("ovf_model_drops", drops, SP ? 10 : 0);
    chk("ovf_total", obs_dat.size() + drops, 32);
    if (obs_dat.size() > 0) chk("ovf_first", obs_dat[0], 8'h00);
    for (int i = 1; i < obs_dat.size(); i++) chk("ovf_increasing", obs_dat[i] > obs_dat[i-1], 1'b1);

    wr(2'b10, 8'h05, e);
    wr(2'b11, 8'h01, e);
    step(5);
    chk("mid_new_set", is_new, 1'b1);
    wr(2'b00, 8'h20, e);
    for (int i = 0; i < 5; i++) wr(2'b01, 8'h40 + 8'(i), e);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    obs_cyc.delete(); obs_dat.delete();
    step(30);
    chk("mid_no_pulses", obs_dat.size(), 0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_is_new", is_new, 1'b0);
    chk("mid_overflow", overflow, 1'b0);
    wr(2'b00, 8'hBD, e);
    wr(2'b01, 8'hC0, e);
    step(2);
    chk("mid_basic_pulse", opl3_reg_wr, 18'h2BDC0);
    step(HOLD + 2);
    chk("mid_basic_busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
